// File: rtl/axi_read_responder.sv
// axi_read_responder: AXI-style burst read responder over an internal word memory with a 2-entry skid buffer.
module axi_read_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int ADDR_BITS = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          axi_araddr,
  input  logic [7:0]           axi_arlen,
  input  logic                 axi_arvalid,
  output logic                 axi_arready,
  output logic                 axi_rvalid,
  input  logic                 axi_rready,
  output logic [31:0]          axi_rdata,
  output logic                 axi_rlast,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [31:0]          load_data
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [8:0]           beats_q, beats_d;
  logic                 rd_v_q, rd_v_d, rd_last_q, rd_last_d;
  logic [1:0]           cnt_q, cnt_d, cnt_after;
  logic [31:0]          d0_q, d0_d, d1_q, d1_d;
  logic                 l0_q, l0_d, l1_q, l1_d;
  logic [31:0]          rd_data_q;
  logic [31:0]          mem [MEM_WORDS];
  logic                 accept, pop, issue;
  logic                 unused_bits;
  assign unused_bits = ^{axi_araddr[31:ADDR_BITS+2], axi_araddr[1:0]};
  assign axi_arready = state_q == IDLE;
  assign axi_rvalid  = cnt_q != 2'd0;
  assign axi_rdata   = d0_q;
  assign axi_rlast   = l0_q;
  assign accept      = axi_arvalid && axi_arready;
  assign pop         = axi_rvalid && axi_rready;
  // A read may issue only if the buffer will still have room once it lands, counting the read already in flight.
  assign issue = state_q == BURST && beats_q != 9'd0 &&
                 ({1'b0, cnt_q} + {2'b0, rd_v_q}) < (3'd2 + {2'b0, pop});
  always_comb begin
    state_d   = accept ? BURST : (pop && l0_q) ? IDLE : state_q;
    idx_d     = accept ? axi_araddr[ADDR_BITS+1:2] : issue ? idx_q + 1'b1 : idx_q;
    beats_d   = accept ? {1'b0, axi_arlen} + 9'd1 : issue ? beats_q - 9'd1 : beats_q;
    rd_v_d    = issue;
    rd_last_d = issue && beats_q == 9'd1;
    cnt_after = cnt_q - {1'b0, pop};
    cnt_d     = cnt_after + {1'b0, rd_v_q};
    d0_d      = (rd_v_q && cnt_after == 2'd0) ? rd_data_q : pop ? d1_q : d0_q;
    l0_d      = (rd_v_q && cnt_after == 2'd0) ? rd_last_q : pop ? l1_q : l0_q;
    d1_d      = (rd_v_q && cnt_after == 2'd1) ? rd_data_q : d1_q;
    l1_d      = (rd_v_q && cnt_after == 2'd1) ? rd_last_q : l1_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      beats_q   <= '0;
      rd_v_q    <= 1'b0;
      rd_last_q <= 1'b0;
      cnt_q     <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      l0_q      <= 1'b0;
      l1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      beats_q   <= beats_d;
      rd_v_q    <= rd_v_d;
      rd_last_q <= rd_last_d;
      cnt_q     <= cnt_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      l0_q      <= l0_d;
      l1_q      <= l1_d;
    end
  end
  // Non-blocking read and write in one block give read-before-write on a shared index.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (issue) rd_data_q <= mem[idx_q];
  end
endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder: randomized and directed burst checks against a memory-array reference model.
module tb_axi_read_responder;
  localparam int MW = 256;
  localparam int AW = 8;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   axi_araddr = '0;
  logic [7:0]    axi_arlen = '0;
  logic          axi_arvalid = 1'b0;
  logic          axi_arready, axi_rvalid, axi_rlast;
  logic          axi_rready = 1'b0;
  logic [31:0]   axi_rdata;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic [31:0]   mdl [MW];
  int total = 0;
  int bad = 0;

  axi_read_responder #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] data);
    load_en = 1'b1;
    load_addr = AW'(idx);
    load_data = data;
    @(negedge clk);
    load_en = 1'b0;
    mdl[idx] = data;
  endtask

  // Starts and ends at a negedge; mode 1 randomizes rready, abort>0 resets after that many beats.
  task automatic burst(input logic [31:0] addr, input int len, input int mode, input int abort, input bit ld_same);
    int start, k, c;
    bit stalled;
    logic [31:0] held_d, exp_d;
    logic held_l;
    start = int'(addr[AW+1:2]);
    k = 0;
    c = 0;
    stalled = 0;
    held_d = '0;
    held_l = 1'b0;
    chk("arready_before", {31'b0, axi_arready}, 32'd1);
    axi_araddr = addr;
    axi_arlen = 8'(len);
    axi_arvalid = 1'b1;
    @(negedge clk);
    axi_arvalid = 1'b0;
    while (k <= len && c < 2000) begin
      if (abort > 0 && k == abort) begin
        reset = 1'b1;
        axi_rready = 1'b0;
        #1;
        chk("abort_rvalid", {31'b0, axi_rvalid}, 32'd0);
        chk("abort_arready", {31'b0, axi_arready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (c == 0) chk("arready_busy", {31'b0, axi_arready}, 32'd0);
      if (c < 2) chk("latency_idle", {31'b0, axi_rvalid}, 32'd0);
      else if (c == 2 || mode == 0) chk("rvalid_on", {31'b0, axi_rvalid}, 32'd1);
      load_en = ld_same && c == 0;
      load_addr = AW'(start);
      load_data = 32'h1234_5678;
      if (stalled) begin
        chk("stall_rvalid", {31'b0, axi_rvalid}, 32'd1);
        chk("stall_rdata", axi_rdata, held_d);
        chk("stall_rlast", {31'b0, axi_rlast}, {31'b0, held_l});
      end
      axi_rready = mode == 0 ? 1'b1 : (c >= 5 && c <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
      if (axi_rvalid && axi_rready) begin
        exp_d = mdl[(start + k) % MW];
        chk("beat_data", axi_rdata, exp_d);
        chk("beat_last", {31'b0, axi_rlast}, {31'b0, k == len});
        k++;
      end
      stalled = axi_rvalid && !axi_rready;
      held_d = axi_rdata;
      held_l = axi_rlast;
      axi_arvalid = 1'($urandom_range(0, 1));
      axi_araddr = $urandom;
      axi_arlen = 8'($urandom);
      @(negedge clk);
      c++;
    end
    if (k <= len) chk("burst_timeout", 32'(k), 32'(len + 1));
    axi_arvalid = 1'b0;
    axi_rready = 1'b0;
    load_en = 1'b0;
    chk("arready_after", {31'b0, axi_arready}, 32'd1);
    chk("rvalid_after", {31'b0, axi_rvalid}, 32'd0);
    if (ld_same) mdl[start] = 32'h1234_5678;
  endtask

  initial begin
    #2;
    chk("rst_arready", {31'b0, axi_arready}, 32'd1);
    chk("rst_rvalid", {31'b0, axi_rvalid}, 32'd0);
    chk("rst_rlast", {31'b0, axi_rlast}, 32'd0);
    chk("rst_rdata", axi_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < MW; i++) load(i, i < 128 ? 32'hA500_0000 + 32'(i) : $urandom);
    burst(32'h1000_0000, 63, 0, 0, 0);
    burst(32'h1000_0000, 63, 1, 0, 0);
    burst(32'(4 * (MW - 2)), 3, 0, 0, 0);
    burst(32'(4 * 5), 0, 0, 0, 0);
    burst(32'h0000_0031, 3, 0, 0, 0);
    mdl[10] = 32'hDEAD_0010;
    load(10, 32'hDEAD_0010);
    burst(32'(4 * 10), 0, 0, 0, 1);
    burst(32'(4 * 10), 0, 0, 0, 0);
    burst(32'h0000_0000, 63, 0, 20, 0);
    burst(32'h0000_0100, 15, 1, 0, 0);
    for (int n = 0; n < 12; n++) begin
      load(int'($urandom_range(0, MW - 1)), $urandom);
      burst($urandom, int'($urandom_range(0, 40)), 1, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
